// File: rtl/adc_spi_config.sv
// 3-wire SPI master for ADC register access. One accepted command becomes one framed 24-bit transfer.
// Command accepted when idle; the next command must wait until the post-frame gap has elapsed.
module adc_spi_config #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic        main_clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [12:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        busy,
    output logic        adc_csb_n,
    output logic        adc_sclk,
    output logic        adc_sdio_out,
    output logic        adc_sdio_oe,
    input  logic        adc_sdio_in
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
    localparam int TMAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                                               : ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
    localparam int TW = $clog2(TMAX + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]    state;
    logic [TW-1:0] tmr;
    logic [PW-1:0] phase;
    logic [4:0]    bit_cnt;
    logic [22:0]   shreg;
    logic          is_read;
    logic [7:0]    rx;
    logic [23:0]   frame;

    // Read frames carry zeros in the data slot; the ADC drives those bits instead.
    assign frame = {cmd_rw, 2'b00, cmd_addr, (cmd_rw ? 8'h00 : cmd_wdata)};
    assign busy  = (state != S_IDLE);

    always_ff @(posedge main_clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cmd_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 8'h00;
            adc_csb_n    <= 1'b1;
            adc_sclk     <= 1'b0;
            adc_sdio_out <= 1'b0;
            adc_sdio_oe  <= 1'b0;
            tmr          <= '0;
            phase        <= '0;
            bit_cnt      <= 5'd0;
            shreg        <= '0;
            is_read      <= 1'b0;
            rx           <= 8'h00;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        state        <= S_SETUP;
                        cmd_ready    <= 1'b0;
                        tmr          <= TW'(CS_SETUP - 1);
                        shreg        <= frame[22:0];
                        is_read      <= cmd_rw;
                        adc_csb_n    <= 1'b0;
                        adc_sdio_oe  <= 1'b1;
                        adc_sdio_out <= frame[23];
                    end
                end
                S_SETUP: begin
                    if (tmr == '0) begin
                        state   <= S_SHIFT;
                        phase   <= '0;
                        bit_cnt <= 5'd23;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                S_SHIFT: begin
                    if (phase != PH_LAST) begin
                        phase <= phase + PW'(1);
                    end else begin
                        phase <= '0;
                        if (!adc_sclk) begin
                            adc_sclk <= 1'b1;
                        end else begin
                            adc_sclk <= 1'b0;
                            // Sample on the last high cycle, just before the falling edge.
                            if (is_read && bit_cnt <= 5'd7)
                                rx <= {rx[6:0], adc_sdio_in};
                            if (bit_cnt == 5'd0) begin
                                state <= S_HOLD;
                                tmr   <= TW'(CS_HOLD - 1);
                            end else begin
                                bit_cnt      <= bit_cnt - 5'd1;
                                shreg        <= {shreg[21:0], 1'b0};
                                adc_sdio_out <= shreg[22];
                                // Bus turnaround once the 16 instruction bits are out.
                                if (is_read && bit_cnt == 5'd8)
                                    adc_sdio_oe <= 1'b0;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (tmr == '0) begin
                        state        <= S_GAP;
                        tmr          <= TW'(CS_GAP - 1);
                        adc_csb_n    <= 1'b1;
                        adc_sdio_oe  <= 1'b0;
                        adc_sdio_out <= 1'b0;
                        rsp_valid    <= 1'b1;
                        if (is_read)
                            rsp_rdata <= rx;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                S_GAP: begin
                    if (tmr == '0) begin
                        state     <= S_IDLE;
                        cmd_ready <= 1'b1;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_config.sv
// Bench for adc_spi_config: default-divider instance plus a CLK_DIV=2 instance, selected by sel.
module tb_adc_spi_config;
    localparam int SETUP = 2;
    localparam int HOLD  = 2;
    localparam int GAP   = 4;

    logic main_clk = 1'b0;
    always #5 main_clk = ~main_clk;

    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_rw = 1'b0;
    logic [12:0] cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic        sdio_in = 1'b0;
    logic        sel = 1'b0;

    logic valid_a, valid_b;
    assign valid_a = cmd_valid & ~sel;
    assign valid_b = cmd_valid & sel;

    logic ready_a, rv_a, busy_a, csb_a, sclk_a, out_a, oe_a;
    logic ready_b, rv_b, busy_b, csb_b, sclk_b, out_b, oe_b;
    logic [7:0] rd_a, rd_b;

    adc_spi_config dut_a (
        .main_clk(main_clk), .rst(rst), .cmd_valid(valid_a), .cmd_ready(ready_a),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rv_a), .rsp_rdata(rd_a), .busy(busy_a), .adc_csb_n(csb_a),
        .adc_sclk(sclk_a), .adc_sdio_out(out_a), .adc_sdio_oe(oe_a), .adc_sdio_in(sdio_in)
    );

    adc_spi_config #(.CLK_DIV(2)) dut_b (
        .main_clk(main_clk), .rst(rst), .cmd_valid(valid_b), .cmd_ready(ready_b),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rv_b), .rsp_rdata(rd_b), .busy(busy_b), .adc_csb_n(csb_b),
        .adc_sclk(sclk_b), .adc_sdio_out(out_b), .adc_sdio_oe(oe_b), .adc_sdio_in(sdio_in)
    );

    logic ready, rv, bsy, csb, sclk, sdo, oe;
    logic [7:0] rdat;
    assign ready = sel ? ready_b : ready_a;
    assign rv    = sel ? rv_b    : rv_a;
    assign bsy   = sel ? busy_b  : busy_a;
    assign csb   = sel ? csb_b   : csb_a;
    assign sclk  = sel ? sclk_b  : sclk_a;
    assign sdo   = sel ? out_b   : out_a;
    assign oe    = sel ? oe_b    : oe_a;
    assign rdat  = sel ? rd_b    : rd_a;

    int n_run = 0;
    int n_fail = 0;
    logic [7:0] exp_rd [2];
    logic [7:0] adc_data = 8'h00;

    // ADC device model: after the 16th SCLK fall it drives its data byte MSB first, noise otherwise.
    initial begin
        int falls;
        logic prev;
        falls = 0;
        prev = 1'b0;
        forever begin
            @(negedge main_clk);
            if (csb !== 1'b0) falls = 0;
            else if (prev === 1'b1 && sclk === 1'b0) falls++;
            prev = sclk;
            if (csb === 1'b0 && falls >= 16 && falls < 24) sdio_in = adc_data[23 - falls];
            else sdio_in = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic rw, input logic [12:0] addr, input logic [7:0] wd,
                        input logic [7:0] rd, input bit keep, input int pulse_at,
                        input string name, output int waited);
        logic r_csb [0:255];
        logic r_sclk [0:255];
        logic r_out [0:255];
        logic r_oe [0:255];
        logic r_rv [0:255];
        logic r_rdy [0:255];
        logic r_bsy [0:255];
        logic [7:0] r_rd [0:255];
        logic [23:0] frame, got;
        logic [7:0] old;
        logic e;
        int dv, L, T, s0, oe_off, nrise, bad, si;
        dv = sel ? 2 : 4;
        si = sel ? 1 : 0;
        L = SETUP + 48 * dv + HOLD;
        T = L + GAP + 1;
        s0 = SETUP + 1;
        oe_off = s0 + 32 * dv;
        frame = {rw, 2'b00, addr, (rw ? 8'h00 : wd)};
        cmd_rw = rw; cmd_addr = addr; cmd_wdata = wd; adc_data = rd; cmd_valid = 1'b1;
        waited = 0;
        while (ready !== 1'b1 && waited < 1000) begin
            @(negedge main_clk);
            waited++;
        end
        n_run++;
        if (waited >= 1000) begin
            n_fail++;
            $display("FAIL %s accept: cmd_ready never rose, waited %0d cycles (limit 1000)", name, waited);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge main_clk);
        #1;
        if (!keep) cmd_valid = 1'b0;
        for (int c = 1; c <= T; c++) begin
            @(negedge main_clk);
            r_csb[c] = csb; r_sclk[c] = sclk; r_out[c] = sdo; r_oe[c] = oe;
            r_rv[c] = rv; r_rdy[c] = ready; r_bsy[c] = bsy; r_rd[c] = rdat;
            if (pulse_at > 0 && c == pulse_at) cmd_valid = 1'b1;
            else if (pulse_at > 0 && c == pulse_at + 1) cmd_valid = 1'b0;
        end

        bad = 0;
        for (int c = 1; c <= T; c++) if (r_csb[c] !== 1'(c > L)) bad++;
        n_run++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s csb_n: %0d cycles wrong, required low exactly on cycles 1..%0d", name, bad, L);
        end

        bad = 0;
        for (int c = 1; c <= T; c++) begin
            e = (c >= s0 && c < s0 + 48 * dv) && (((c - s0) % (2 * dv)) >= dv);
            if (r_sclk[c] !== e) bad++;
        end
        n_run++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s sclk: %0d cycles differ from the expected waveform, required 0", name, bad);
        end

        nrise = 0;
        got = '0;
        for (int c = 2; c <= T; c++) begin
            if (r_sclk[c] === 1'b1 && r_sclk[c-1] === 1'b0) begin
                got = {got[22:0], r_out[c]};
                nrise++;
            end
        end
        n_run++;
        if (got !== frame || nrise != 24) begin
            n_fail++;
            $display("FAIL %s stream: got 0x%06h over %0d rises, expected 0x%06h over 24", name, got, nrise, frame);
        end

        bad = 0;
        if (r_out[1] !== frame[23]) bad++;
        for (int c = 2; c <= L; c++)
            if (r_out[c] !== r_out[c-1] && !(r_sclk[c-1] === 1'b1 && r_sclk[c] === 1'b0)) bad++;
        n_run++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s sdio_timing: %0d illegal sdio_out changes, required 0", name, bad);
        end

        bad = 0;
        for (int c = 1; c <= T; c++) begin
            e = (c <= L) && (!rw || c < oe_off);
            if (r_oe[c] !== e) bad++;
        end
        n_run++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s sdio_oe: %0d cycles wrong, required 0 (read turnaround at cycle %0d)", name, bad, oe_off);
        end

        bad = 0;
        for (int c = 1; c <= T; c++) if (r_rv[c] !== 1'(c == L + 1)) bad++;
        n_run++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s rsp_valid: %0d cycles wrong, required single pulse at cycle %0d", name, bad, L + 1);
        end

        bad = 0;
        for (int c = 1; c <= T; c++) begin
            if (r_rdy[c] !== 1'(c == T)) bad++;
            if (r_bsy[c] !== 1'(c < T)) bad++;
        end
        n_run++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s ready_busy: %0d cycles wrong, required busy to cycle %0d and ready at %0d", name, bad, T - 1, T);
        end

        old = exp_rd[si];
        if (rw) exp_rd[si] = rd;
        n_run++;
        if (r_rd[L] !== old || r_rd[L+1] !== exp_rd[si] || r_rd[T] !== exp_rd[si]) begin
            n_fail++;
            $display("FAIL %s rsp_rdata: got 0x%02h/0x%02h/0x%02h, expected 0x%02h/0x%02h/0x%02h",
                     name, r_rd[L], r_rd[L+1], r_rd[T], old, exp_rd[si], exp_rd[si]);
        end
    endtask

    task automatic test_reset;
        logic [14:0] got;
        sel = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge main_clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            got = {ready, rv, rdat, bsy, csb, sclk, sdo, oe};
            n_run++;
            if (got !== 15'b0_0_00000000_0_1_0_0_0) begin
                n_fail++;
                $display("FAIL reset_values[%0d]: got 0x%04h, expected 0x%04h", s, got, 15'b0_0_00000000_0_1_0_0_0);
            end
        end
        sel = 1'b0;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        @(negedge main_clk);
        rst = 1'b0;
        @(negedge main_clk);
        n_run++;
        if (ready !== 1'b1 || bsy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: cmd_ready=%b busy=%b, expected 1 and 0", ready, bsy);
        end
    endtask

    task automatic test_write;
        int w;
        sel = 1'b0;
        send(1'b0, 13'h014, 8'h41, 8'h00, 1'b0, 0, "write_014", w);
        for (int i = 0; i < 3; i++)
            send(1'b0, 13'($urandom), 8'($urandom), 8'($urandom), 1'b0, 0, "write_rand", w);
    endtask

    task automatic test_read;
        int w;
        sel = 1'b0;
        send(1'b1, 13'h001, 8'h00, 8'hA5, 1'b0, 0, "read_001", w);
        for (int i = 0; i < 2; i++)
            send(1'b1, 13'($urandom), 8'($urandom), 8'($urandom), 1'b0, 0, "read_rand", w);
    endtask

    task automatic test_back_to_back;
        int w;
        sel = 1'b0;
        send(1'b0, 13'h0A5, 8'h3C, 8'h00, 1'b1, 0, "b2b_first", w);
        send(1'b0, 13'h15A, 8'hC3, 8'h00, 1'b0, 0, "b2b_second", w);
        n_run++;
        if (w != 0) begin
            n_fail++;
            $display("FAIL b2b_accept: second command waited %0d cycles after the gap, expected 0", w);
        end
    endtask

    task automatic test_reset_mid;
        int waited, pulses, stray;
        sel = 1'b0;
        cmd_rw = 1'b0; cmd_addr = 13'h1234; cmd_wdata = 8'h77; cmd_valid = 1'b1;
        waited = 0;
        while (ready !== 1'b1 && waited < 1000) begin
            @(negedge main_clk);
            waited++;
        end
        @(posedge main_clk);
        #1 cmd_valid = 1'b0;
        repeat (99) @(negedge main_clk);
        @(posedge main_clk);
        #1 rst = 1'b1;
        @(negedge main_clk);
        n_run++;
        if (csb !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_midframe: csb_n=%b at cycle 100, expected 0", csb);
        end
        @(negedge main_clk);
        n_run++;
        if (csb !== 1'b1 || sclk !== 1'b0 || oe !== 1'b0 || bsy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: csb_n=%b sclk=%b oe=%b busy=%b, expected 1 0 0 0", csb, sclk, oe, bsy);
        end
        rst = 1'b0;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        pulses = 0;
        stray = 0;
        repeat (220) begin
            @(negedge main_clk);
            if (rv === 1'b1) pulses++;
            if (csb !== 1'b1) stray++;
        end
        n_run++;
        if (pulses != 0 || stray != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: %0d rsp_valid pulses, %0d csb_n low cycles, expected 0 and 0", pulses, stray);
        end
        send(1'b0, 13'h0F0, 8'h5A, 8'h00, 1'b0, 0, "after_abort", waited);
    endtask

    task automatic test_clk_div2;
        int w;
        @(negedge main_clk);
        sel = 1'b1;
        send(1'b0, 13'h014, 8'h41, 8'h00, 1'b0, 0, "div2_write", w);
        send(1'b1, 13'($urandom), 8'h00, 8'($urandom), 1'b0, 0, "div2_read", w);
        send(1'b0, 13'($urandom), 8'($urandom), 8'h00, 1'b0, 0, "div2_write_rand", w);
        sel = 1'b0;
    endtask

    task automatic test_busy_pulse;
        int w, extra;
        sel = 1'b0;
        send(1'b0, 13'h0033, 8'h99, 8'h00, 1'b0, 50, "busy_pulse", w);
        extra = 0;
        repeat (250) begin
            @(negedge main_clk);
            if (csb !== 1'b1 || bsy !== 1'b0) extra++;
        end
        n_run++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL busy_pulse_extra: %0d active cycles after the frame, expected 0", extra);
        end
    endtask

    task automatic test_rst_with_valid;
        sel = 1'b0;
        @(negedge main_clk);
        rst = 1'b1;
        cmd_valid = 1'b1;
        cmd_rw = 1'b0; cmd_addr = 13'h0555; cmd_wdata = 8'hAA;
        @(negedge main_clk);
        n_run++;
        if (bsy !== 1'b0 || csb !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_priority: busy=%b csb_n=%b, expected 0 and 1", bsy, csb);
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        repeat (2) @(negedge main_clk);
        n_run++;
        if (bsy !== 1'b0 || csb !== 1'b1 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_priority_after: busy=%b csb_n=%b ready=%b, expected 0 1 1", bsy, csb, ready);
        end
    endtask

    initial begin
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_clk_div2();
        test_busy_pulse();
        test_rst_with_valid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
